// File: rtl/rx_lane_arbiter.sv
// rx_lane_arbiter: round-robin arbiter that moves packets from NUM_LANES
// serial receive lanes into a single downstream FIFO port through one
// output register (EMPTY/FULL two-state FSM, one packet per cycle sustained).
// Optional feature: define RX_ARB_PKT_COUNT_EN to add a saturating 16-bit
// pkt_count output counting output transfers.
module rx_lane_arbiter #(
    parameter int NUM_LANES     = 4,
    parameter int PACKET_LENGTH = 32
) (
    input  logic                               aclk,
    input  logic                               aresetn,
    input  logic                               enable,
    input  logic [NUM_LANES*PACKET_LENGTH-1:0] lane_data,
    input  logic [NUM_LANES-1:0]               lane_valid,
    output logic [NUM_LANES-1:0]               lane_ready,
    output logic [PACKET_LENGTH-1:0]           fifo_data,
    output logic [2:0]                         fifo_lane,
    output logic                               fifo_valid,
    input  logic                               fifo_ready,
    output logic                               busy
`ifdef RX_ARB_PKT_COUNT_EN
    ,
    output logic [15:0]                        pkt_count
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t                   state;
    logic [2:0]               last_grant;
    logic [3:0]               cand;
    logic                     grant_found;
    logic [2:0]               grant_idx;
    logic [PACKET_LENGTH-1:0] sel_data;
    logic                     out_free;
    logic                     out_xfer;
    logic                     lane_xfer;

    // The output register can take a new packet when empty or draining this cycle.
    assign out_free = !fifo_valid || fifo_ready;
    assign out_xfer = fifo_valid && fifo_ready;
    assign lane_xfer = |lane_ready;

    // Busy covers a held packet and any lane still asking; forced low in reset.
    assign busy = aresetn && (fifo_valid || (|lane_valid));

    // Round-robin search starting one past the last granted lane, with wrap.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NUM_LANES; k++) begin
            cand = {1'b0, last_grant} + 4'(k);
            if (cand >= 4'(NUM_LANES)) begin
                cand = cand - 4'(NUM_LANES);
            end
            for (int i = 0; i < NUM_LANES; i++) begin
                if (!grant_found && (cand == 4'(i)) && lane_valid[i]) begin
                    grant_found = 1'b1;
                    grant_idx   = 3'(i);
                end
            end
        end
    end

    // Grant the winner only when allowed and the output register has room.
    always_comb begin
        lane_ready = '0;
        sel_data   = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (grant_idx == 3'(i)) begin
                sel_data = lane_data[i*PACKET_LENGTH +: PACKET_LENGTH];
                lane_ready[i] = aresetn && enable && out_free && grant_found;
            end
        end
    end

    // Output register FSM: load on lane transfer, clear on drain without reload.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= EMPTY;
            fifo_valid <= 1'b0;
            fifo_data  <= '0;
            fifo_lane  <= '0;
            last_grant <= 3'(NUM_LANES - 1);
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            case (state)
                EMPTY: begin
                    if (lane_xfer) begin
                        state      <= FULL;
                        fifo_valid <= 1'b1;
                        fifo_data  <= sel_data;
                        fifo_lane  <= grant_idx;
                        last_grant <= grant_idx;
                    end
                end
                FULL: begin
                    if (lane_xfer) begin
                        fifo_valid <= 1'b1;
                        fifo_data  <= sel_data;
                        fifo_lane  <= grant_idx;
                        last_grant <= grant_idx;
                    end else if (out_xfer) begin
                        state      <= EMPTY;
                        fifo_valid <= 1'b0;
                    end
                end
                default: begin
                    state      <= EMPTY;
                    fifo_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef RX_ARB_PKT_COUNT_EN
    // Count output transfers, sticking at all-ones.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pkt_count <= '0;
        end else if (out_xfer && (pkt_count != 16'hFFFF)) begin
            pkt_count <= pkt_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rx_lane_arbiter.sv
// Directed testbench for rx_lane_arbiter (NUM_LANES=4, PACKET_LENGTH=32).
// Inputs change 1 ns after a rising edge; outputs are sampled 1-2 ns later.
module tb_rx_lane_arbiter;

    logic        aclk;
    logic        aresetn;
    logic        enable;
    logic [31:0] ld [4];
    logic [127:0] lane_data;
    logic [3:0]  lane_valid;
    logic [3:0]  lane_ready;
    logic [31:0] fifo_data;
    logic [2:0]  fifo_lane;
    logic        fifo_valid;
    logic        fifo_ready;
    logic        busy;
`ifdef RX_ARB_PKT_COUNT_EN
    logic [15:0] pkt_count;
`endif

    int checks   = 0;
    int failures = 0;

    assign lane_data = {ld[3], ld[2], ld[1], ld[0]};

    rx_lane_arbiter #(
        .NUM_LANES     (4),
        .PACKET_LENGTH (32)
    ) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .enable     (enable),
        .lane_data  (lane_data),
        .lane_valid (lane_valid),
        .lane_ready (lane_ready),
        .fifo_data  (fifo_data),
        .fifo_lane  (fifo_lane),
        .fifo_valid (fifo_valid),
        .fifo_ready (fifo_ready),
        .busy       (busy)
`ifdef RX_ARB_PKT_COUNT_EN
        ,
        .pkt_count  (pkt_count)
`endif
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    int exp_seq [6] = '{3, 0, 1, 2, 3, 0};
    logic [31:0] exp_data [4];

    initial begin
        aresetn    = 1'b0;
        enable     = 1'b1;
        fifo_ready = 1'b0;
        lane_valid = 4'b1111;
        ld[0] = 32'hA0A0A0A0;
        ld[1] = 32'hB1B1B1B1;
        ld[2] = 32'hDEADBEEF;
        ld[3] = 32'hC3C3C3C3;

        // Reset values, with every lane requesting.
        tick();
        check("rst_fifo_valid", 32'(fifo_valid), 32'd0);
        check("rst_fifo_data", fifo_data, 32'd0);
        check("rst_fifo_lane", 32'(fifo_lane), 32'd0);
        check("rst_lane_ready", 32'(lane_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        tick();
        aresetn    = 1'b1;
        lane_valid = 4'b0000;
        tick();

        // Single lane 2 request.
        lane_valid = 4'b0100;
        fifo_ready = 1'b1;
        #1;
        check("single_lane_ready", 32'(lane_ready), 32'h4);
        check("single_busy", 32'(busy), 32'd1);
        tick();
        lane_valid = 4'b0000;
        check("single_valid", 32'(fifo_valid), 32'd1);
        check("single_data", fifo_data, 32'hDEADBEEF);
        check("single_lane", 32'(fifo_lane), 32'd2);
        tick();
        check("single_drain_valid", 32'(fifo_valid), 32'd0);
        check("single_drain_busy", 32'(busy), 32'd0);

        // All lanes requesting: rotation resumes after lane 2.
        lane_valid = 4'b1111;
        exp_data[0] = 32'hA0A0A0A0;
        exp_data[1] = 32'hB1B1B1B1;
        exp_data[2] = 32'hDEADBEEF;
        exp_data[3] = 32'hC3C3C3C3;
        #1;
        for (int i = 0; i < 6; i++) begin
            check("rr_lane_ready", 32'(lane_ready), 32'(1) << exp_seq[i]);
            tick();
            check("rr_valid", 32'(fifo_valid), 32'd1);
            check("rr_lane", 32'(fifo_lane), 32'(exp_seq[i]));
            check("rr_data", fifo_data, exp_data[exp_seq[i]]);
        end

        // Backpressure: lane 0 packet held while lane data changes.
        fifo_ready = 1'b0;
        ld[0] = 32'h10101010;
        ld[1] = 32'h21212121;
        ld[2] = 32'h32323232;
        ld[3] = 32'h43434343;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_lane_ready", 32'(lane_ready), 32'd0);
            check("bp_data", fifo_data, 32'hA0A0A0A0);
            check("bp_lane", 32'(fifo_lane), 32'd0);
            check("bp_valid", 32'(fifo_valid), 32'd1);
            tick();
        end
        fifo_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(lane_ready), 32'h2);
        tick();
        check("bp_release_lane", 32'(fifo_lane), 32'd1);
        check("bp_release_data", fifo_data, 32'h21212121);

        // Enable low while FULL: packet held, then drains, no new grant.
        enable     = 1'b0;
        fifo_ready = 1'b0;
        #1;
        check("en_lane_ready", 32'(lane_ready), 32'd0);
        check("en_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("en_hold_valid", 32'(fifo_valid), 32'd1);
            check("en_hold_lane", 32'(fifo_lane), 32'd1);
            check("en_hold_data", fifo_data, 32'h21212121);
        end
        fifo_ready = 1'b1;
        #1;
        check("en_drain_ready", 32'(lane_ready), 32'd0);
        tick();
        check("en_drain_valid", 32'(fifo_valid), 32'd0);
        check("en_drain_busy", 32'(busy), 32'd1);
        check("en_drain_lane_ready", 32'(lane_ready), 32'd0);
        tick();
        check("en_idle_valid", 32'(fifo_valid), 32'd0);

        // Re-enable: rotation continues from lane 1, so lane 2 wins.
        enable     = 1'b1;
        fifo_ready = 1'b0;
        #1;
        check("reen_lane_ready", 32'(lane_ready), 32'h4);
        tick();
        check("reen_valid", 32'(fifo_valid), 32'd1);
        check("reen_lane", 32'(fifo_lane), 32'd2);
        check("reen_full_ready", 32'(lane_ready), 32'd0);

        // Reset while a packet is stalled.
        aresetn = 1'b0;
        #1;
        check("midrst_valid", 32'(fifo_valid), 32'd0);
        check("midrst_data", fifo_data, 32'd0);
        check("midrst_lane_ready", 32'(lane_ready), 32'd0);
`ifdef RX_ARB_PKT_COUNT_EN
        check("midrst_pkt_count", 32'(pkt_count), 32'd0);
`endif
        tick();
        aresetn    = 1'b1;
        lane_valid = 4'b1010;
        fifo_ready = 1'b1;
        #1;
        check("postrst_first_ready", 32'(lane_ready), 32'h2);
        tick();
        check("postrst_first_lane", 32'(fifo_lane), 32'd1);
        check("postrst_second_ready", 32'(lane_ready), 32'h8);
        tick();
        check("postrst_second_lane", 32'(fifo_lane), 32'd3);
        lane_valid = 4'b0000;
        tick();
        check("postrst_drain_valid", 32'(fifo_valid), 32'd0);

`ifdef RX_ARB_PKT_COUNT_EN
        // Counter saturation.
        lane_valid = 4'b0001;
        fifo_ready = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            tick();
        end
        check("cnt_saturate", 32'(pkt_count), 32'h0000FFFF);
        tick();
        tick();
        check("cnt_hold", 32'(pkt_count), 32'h0000FFFF);
        lane_valid = 4'b0000;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
